enc_4to2_hs: RTL and testbench



---
 rtl/enc_4to2_hs.sv | 117 +++++++++++
 tb/tb_enc_4to2_hs.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/enc_4to2_hs.sv
// Sequential 4-to-2 encoder with stability qualification
// and a valid/ready handshake, one code per assertion event.
module enc_4to2_hs #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    input  logic       ready,
    output logic [1:0] code,
    output logic       valid,
    output logic       multi_hot,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        HOLD,
        WAIT_REL
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       samp;

    // Index of the highest set bit; d[3] wins over lower lines.
    function automatic logic [1:0] enc(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        priority case (1'b1)
            p[3]:    r = 2'd3;
            p[2]:    r = 2'd2;
            p[1]:    r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // More than one bit set: clearing the lowest set bit leaves something.
    function automatic logic mh(input logic [3:0] p);
        return |(p & (p - 4'd1));
    endfunction

    // Qualification FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            samp      <= 4'd0;
            code      <= 2'd0;
            valid     <= 1'b0;
            multi_hot <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (d != 4'd0) begin
                        samp <= d;
                        cnt  <= ONE;
                        busy <= 1'b1;
                        if (STABLE_CYCLES == 1) begin
                            state     <= HOLD;
                            code      <= enc(d);
                            multi_hot <= mh(d);
                            valid     <= 1'b1;
                        end else begin
                            state <= QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (d == 4'd0) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (d != samp) begin
                        // A bounce restarts qualification on the new pattern.
                        samp <= d;
                        cnt  <= ONE;
                    end else if (cnt == LAST) begin
                        state     <= HOLD;
                        code      <= enc(samp);
                        multi_hot <= mh(samp);
                        valid     <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    // Only a full release re-arms the encoder.
                    if (d == 4'd0) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_4to2_hs.sv
// Scoreboard bench for enc_4to2_hs with directed vectors.
// Expected codes are queued by stimulus and popped by a monitor.
module tb_enc_4to2_hs;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic       ready;
    logic [1:0] code;
    logic       valid;
    logic       multi_hot;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // {code, multi_hot} expected per accepted handshake
    logic [2:0] sb[$];

    enc_4to2_hs #(
        .STABLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .d(d),
        .ready(ready),
        .code(code),
        .valid(valid),
        .multi_hot(multi_hot),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int exp);
        int k;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            k++;
            if (valid === 1'b1) break;
        end
        check({name, "_latency"}, (valid === 1'b1) ? k : -1, exp);
    endtask

    task automatic release_d(input string name);
        d = 4'd0;
        tick();
        tick();
        check({name, "_idle"}, {valid, busy}, 2'b00);
    endtask

    task automatic check_zero(input string name);
        check({name, "_outs"}, {code, valid, multi_hot, busy}, 5'd0);
    endtask

    // Handshake completes at the next rising edge; inputs only
    // change just after rising edges, so negedge values are final.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got code=%0d mh=%0b expected none",
                         code, multi_hot);
            end else begin
                logic [2:0] e;
                e = sb.pop_front();
                if ({code, multi_hot} !== e) begin
                    errors++;
                    $display("FAIL handshake: got code=%0d mh=%0b expected code=%0d mh=%0b",
                             code, multi_hot, e[2:1], e[0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int highs;
        rst_n = 1'b0;
        d     = 4'b1111;
        ready = 1'b0;

        // reset with all lines asserted
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        sb.push_back({2'd3, 1'b1});
        wait_valid("reset_release", 4);
        ready = 1'b1;
        tick();
        check("reset_accept_valid", valid, 1'b0);
        release_d("reset_release");

        // single hot with ready held high
        d = 4'b0100;
        sb.push_back({2'd2, 1'b0});
        wait_valid("single2", 4);
        tick();
        check("single2_fall", valid, 1'b0);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid === 1'b1) highs++;
        end
        check("single2_no_repeat", highs, 0);
        d = 4'd0;
        tick();
        d = 4'b0001;
        sb.push_back({2'd0, 1'b0});
        wait_valid("single0", 4);
        release_d("single0");

        // bounce restarts qualification
        d = 4'b0010;
        tick();
        d = 4'b0000;
        tick();
        d = 4'b0010;
        tick();
        check("bounce_no_valid", valid, 1'b0);
        d = 4'b1000;
        sb.push_back({2'd3, 1'b0});
        wait_valid("bounce", 4);
        release_d("bounce");

        // multi-hot patterns
        d = 4'b1010;
        sb.push_back({2'd3, 1'b1});
        wait_valid("multi_1010", 4);
        release_d("multi_1010");
        d = 4'b0011;
        sb.push_back({2'd1, 1'b1});
        wait_valid("multi_0011", 4);
        release_d("multi_0011");

        // backpressure holds the code steady
        ready = 1'b0;
        d = 4'b0100;
        sb.push_back({2'd2, 1'b0});
        wait_valid("bp", 4);
        d = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {code, valid, multi_hot}, {2'd2, 1'b1, 1'b0});
        end
        ready = 1'b1;
        tick();
        check("bp_accept", valid, 1'b0);
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid === 1'b1 || busy !== 1'b1) highs++;
        end
        check("bp_wait_rel", highs, 0);
        d = 4'd0;
        tick();
        check("bp_idle", busy, 1'b0);
        d = 4'b0001;
        sb.push_back({2'd0, 1'b0});
        wait_valid("bp_next", 4);
        release_d("bp_next");

        // reset during qualification
        d = 4'b0010;
        tick();
        tick();
        check("qual_busy", {valid, busy}, 2'b01);
        rst_n = 1'b0;
        tick();
        check_zero("rst_qual");
        rst_n = 1'b1;
        sb.push_back({2'd1, 1'b0});
        wait_valid("rst_qual", 4);
        release_d("rst_qual");

        // reset while holding a pending code
        ready = 1'b0;
        d = 4'b1000;
        wait_valid("hold_pre", 4);
        check("hold_pre_code", {code, multi_hot}, {2'd3, 1'b0});
        rst_n = 1'b0;
        tick();
        check_zero("rst_hold");
        rst_n = 1'b1;
        ready = 1'b1;
        sb.push_back({2'd3, 1'b0});
        wait_valid("rst_hold", 4);
        release_d("rst_hold");

        tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
